// File: rtl/tester_pkg.sv
// tester_pkg: shared constants for the part_tester command processor.
//   - Host command bytes (ASCII) of the r s g i o e f d protocol.
//   - ASCII '0' / '1' used for bit payloads in both directions.
//   - Command-processor FSM state encoding (exported on the state port).
package tester_pkg;

    localparam logic [7:0] CMD_RESET       = 8'h72;  // 'r'
    localparam logic [7:0] CMD_SET_STATE   = 8'h73;  // 's'
    localparam logic [7:0] CMD_GET_STATE   = 8'h67;  // 'g'
    localparam logic [7:0] CMD_SET_INPUTS  = 8'h69;  // 'i'
    localparam logic [7:0] CMD_GET_OUTPUTS = 8'h6F;  // 'o'
    localparam logic [7:0] CMD_EXECUTE     = 8'h65;  // 'e'
    localparam logic [7:0] CMD_FREE_RUN    = 8'h66;  // 'f'
    localparam logic [7:0] CMD_DONE        = 8'h64;  // 'd'

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;

    typedef enum logic [3:0] {
        ST_BOOT      = 4'd0,
        ST_RST_PART  = 4'd1,
        ST_LEN_HI    = 4'd2,
        ST_LEN_LO    = 4'd3,
        ST_EXEC      = 4'd4,
        ST_IDLE      = 4'd5,
        ST_FREE      = 4'd6,
        ST_SHIFT_IN  = 4'd7,
        ST_SEND      = 4'd8,
        ST_SEND_WAIT = 4'd9,
        ST_CLK_PULSE = 4'd10
    } state_t;

endpackage

// File: rtl/part_clk_gen.sv
// part_clk_gen: part clock generator.
//   clk, rstn  : system clock, async active-low reset
//   pulse      : request a pulse (1 cycle high, then 1 cycle low); held by the
//                caller for as long as more pulses are wanted
//   free       : toggle part_clk every cycle while high
//   part_clk   : generated part clock (registered)
//   done       : high in the low cycle that completes a requested pulse
module part_clk_gen (
    input  logic clk,
    input  logic rstn,
    input  logic pulse,
    input  logic free,
    output logic part_clk,
    output logic done
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            part_clk <= 1'b0;
            done     <= 1'b0;
        end else begin
            // A high phase always lasts exactly one cycle.
            part_clk <= !part_clk && (pulse || free);
            // Free-run edges never count as completed pulses.
            done     <= part_clk && !free;
        end
    end

endmodule

// File: rtl/tester_cmd_proc.sv
// tester_cmd_proc: host command responder for part_tester.
//   clk, rstn           : system clock, async active-low reset
//   rx_rcv, rx_data     : received byte strobe / byte from uart_rx
//   tx_start, tx_data   : transmit request / byte to uart_tx
//   tx_ready            : uart_tx idle
//   part_clk/rstn/se/tm/si, part_pis : drives to the part under test
//   part_so, part_pos   : scan-out and primary outputs sampled from the part
//   state               : current FSM state
module tester_cmd_proc
    import tester_pkg::*;
#(
    parameter int NPIS       = 14,
    parameter int NPOS       = 11,
    parameter int RST_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx_rcv,
    input  logic [7:0]      rx_data,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            part_clk,
    output logic            part_rstn,
    output logic            part_se,
    output logic            part_tm,
    output logic            part_si,
    input  logic            part_so,
    output logic [1:NPIS]   part_pis,
    input  logic [1:NPOS]   part_pos,
    output logic [3:0]      state
);

    localparam logic [NPIS-1:0] PIS_FIRST = {1'b1, {(NPIS-1){1'b0}}};

    state_t        state_q, state_nx;
    logic [7:0]    cmd_q;
    logic [15:0]   count_q, index_q, send_idx;
    logic          last, rst_done, len_nz, rx_bit, is_done_byte;
    logic          scan_cmd, send_cmd, send_bit;
    logic          pulse_req, free_req, clk_done;
    logic [7:0]    send_byte;
    logic [NPOS-1:0] pos_sh;
    logic [NPIS-1:0] pis_mask;

    assign state        = state_q;
    assign last         = (index_q == count_q - 16'd1);
    assign rst_done     = (index_q == 16'(RST_CYCLES - 1));
    assign len_nz       = (count_q[15:8] != 8'd0) || (rx_data != 8'd0);
    assign rx_bit       = (rx_data == ASCII_1);
    assign is_done_byte = rx_rcv && (rx_data == CMD_DONE);
    assign scan_cmd     = (cmd_q == CMD_SET_STATE) || (cmd_q == CMD_GET_STATE);
    assign send_cmd     = (cmd_q == CMD_GET_STATE) || (cmd_q == CMD_GET_OUTPUTS);

    // Byte about to be loaded: SEND_WAIT reloads for the next k, so look one ahead.
    assign send_idx  = (state_q == ST_SEND_WAIT) ? index_q + 16'd1 : index_q;
    // part_pos[1] is the MSB; shifting past NPOS yields 0 for k > NPOS.
    assign pos_sh    = part_pos << send_idx;
    assign send_bit  = (cmd_q == CMD_GET_STATE) ? part_so : pos_sh[NPOS-1];
    assign send_byte = {ASCII_0[7:1], send_bit};
    // One-hot select of part_pis[index+1]; empty once index >= NPIS.
    assign pis_mask  = PIS_FIRST >> index_q;

    part_clk_gen u_clk_gen (
        .clk      (clk),
        .rstn     (rstn),
        .pulse    (pulse_req),
        .free     (free_req),
        .part_clk (part_clk),
        .done     (clk_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_BOOT;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx  = state_q;
        pulse_req = 1'b0;
        free_req  = 1'b0;
        case (state_q)
            ST_BOOT: state_nx = ST_IDLE;
            ST_IDLE: if (rx_rcv) begin
                case (rx_data)
                    CMD_RESET:                 state_nx = ST_RST_PART;
                    CMD_EXECUTE, CMD_SET_STATE, CMD_GET_STATE,
                    CMD_SET_INPUTS, CMD_GET_OUTPUTS: state_nx = ST_LEN_HI;
                    CMD_FREE_RUN:              state_nx = ST_FREE;
                    default:                   state_nx = ST_IDLE;
                endcase
            end
            ST_RST_PART: if (rst_done) state_nx = ST_IDLE;
            ST_LEN_HI:   if (rx_rcv) state_nx = ST_LEN_LO;
            ST_LEN_LO: if (rx_rcv) begin
                if (!len_nz)                   state_nx = ST_IDLE;
                else if (cmd_q == CMD_EXECUTE) state_nx = ST_EXEC;
                else if (send_cmd)             state_nx = ST_SEND;
                else                           state_nx = ST_SHIFT_IN;
            end
            ST_EXEC: begin
                // Chain the next pulse straight into the completing low cycle.
                pulse_req = !(clk_done && last);
                if (clk_done && last) state_nx = ST_IDLE;
            end
            ST_SHIFT_IN: if (rx_rcv) begin
                if (cmd_q == CMD_SET_STATE) state_nx = ST_CLK_PULSE;
                else if (last)              state_nx = ST_IDLE;
            end
            ST_CLK_PULSE: begin
                pulse_req = !clk_done;
                if (clk_done) begin
                    if (last)                        state_nx = ST_IDLE;
                    else if (cmd_q == CMD_GET_STATE) state_nx = ST_SEND;
                    else                             state_nx = ST_SHIFT_IN;
                end
            end
            ST_SEND:      if (!tx_ready) state_nx = ST_SEND_WAIT;
            ST_SEND_WAIT: if (tx_ready) begin
                if (cmd_q == CMD_GET_STATE) state_nx = ST_CLK_PULSE;
                else if (last)              state_nx = ST_IDLE;
                else                        state_nx = ST_SEND;
            end
            ST_FREE: begin
                // Drop the request on 'd' so a low clock stays low; a high one falls anyway.
                free_req = !is_done_byte;
                if (is_done_byte) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_start  <= 1'b0;
            tx_data   <= 8'd0;
            part_rstn <= 1'b1;
            part_se   <= 1'b0;
            part_tm   <= 1'b0;
            part_si   <= 1'b0;
            part_pis  <= '0;
            count_q   <= 16'd0;
            index_q   <= 16'd0;
            cmd_q     <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (rx_rcv) begin
                    cmd_q   <= rx_data;
                    index_q <= 16'd0;
                    if (rx_data == CMD_RESET) part_rstn <= 1'b0;
                end
                ST_RST_PART: begin
                    index_q <= index_q + 16'd1;
                    if (rst_done) part_rstn <= 1'b1;
                end
                ST_LEN_HI: if (rx_rcv) count_q[15:8] <= rx_data;
                ST_LEN_LO: if (rx_rcv) begin
                    count_q[7:0] <= rx_data;
                    if (len_nz && scan_cmd) begin
                        part_se <= 1'b1;
                        part_tm <= 1'b1;
                    end
                    if (len_nz && send_cmd) begin
                        tx_start <= 1'b1;
                        tx_data  <= send_byte;
                    end
                end
                ST_SHIFT_IN: if (rx_rcv) begin
                    if (cmd_q == CMD_SET_STATE) begin
                        part_si <= rx_bit;
                    end else begin
                        part_pis <= rx_bit ? (part_pis | pis_mask) : (part_pis & ~pis_mask);
                        index_q  <= index_q + 16'd1;
                    end
                end
                ST_EXEC: if (clk_done) index_q <= index_q + 16'd1;
                ST_CLK_PULSE: if (clk_done) begin
                    index_q <= index_q + 16'd1;
                    if (last) begin
                        part_se <= 1'b0;
                        part_tm <= 1'b0;
                    end else if (cmd_q == CMD_GET_STATE) begin
                        tx_start <= 1'b1;
                        tx_data  <= send_byte;
                    end
                end
                ST_SEND: if (!tx_ready) tx_start <= 1'b0;
                ST_SEND_WAIT: if (tx_ready && cmd_q == CMD_GET_OUTPUTS) begin
                    index_q <= index_q + 16'd1;
                    if (!last) begin
                        tx_start <= 1'b1;
                        tx_data  <= send_byte;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tester_cmd_proc.sv
// tb_tester_cmd_proc: directed stimulus with a scoreboard for transmitted
// bytes and scan-in bits, a small UART-tx model and a scan-chain loopback.
`timescale 1ns/1ps
module tb_tester_cmd_proc;

    localparam int NPIS = 14;
    localparam int NPOS = 11;
    localparam int BUDGET = 4000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            rx_rcv = 1'b0;
    logic [7:0]      rx_data = 8'd0;
    logic            tx_start, tx_ready;
    logic [7:0]      tx_data;
    logic            part_clk, part_rstn, part_se, part_tm, part_si, part_so;
    logic [1:NPIS]   part_pis;
    logic [1:NPOS]   part_pos = '0;
    logic [3:0]      state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_tx[$];
    logic       exp_si[$];
    logic       mon_si = 1'b0;
    logic       mon_scan = 1'b0;
    logic [7:0] chain = 8'd0;
    logic       pclk_prev = 1'b0;
    int         edges = 0;
    int         rst_low = 0;
    int         tx_busy;

    always #5 clk = ~clk;

    tester_cmd_proc #(.NPIS(NPIS), .NPOS(NPOS), .RST_CYCLES(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_rcv    (rx_rcv),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .part_clk  (part_clk),
        .part_rstn (part_rstn),
        .part_se   (part_se),
        .part_tm   (part_tm),
        .part_si   (part_si),
        .part_so   (part_so),
        .part_pis  (part_pis),
        .part_pos  (part_pos),
        .state     (state)
    );

    // Scan-chain loopback: first bit shifted in is the first bit shifted out.
    assign part_so = chain[7];
    always @(posedge part_clk) if (part_se) chain <= {chain[6:0], part_si};

    // uart_tx model: accepts a start while idle, then stays busy a few cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ready <= 1'b1;
            tx_busy  <= 0;
        end else if (tx_ready) begin
            if (tx_start) begin
                tx_ready <= 1'b0;
                tx_busy  <= 4;
            end
        end else if (tx_busy == 0) begin
            tx_ready <= 1'b1;
        end else begin
            tx_busy <= tx_busy - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out or unexpected event", name);
    endtask

    // Monitor: compares transmitted bytes and scan-in bits against the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (tx_start && tx_ready) begin
                if (exp_tx.size() == 0) fail("tx_unexpected");
                else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            if (part_clk && !pclk_prev) begin
                edges <= edges + 1;
                if (mon_scan) chk("scan_se_tm", 32'({part_se, part_tm}), 32'd3);
                if (mon_si) begin
                    if (exp_si.size() == 0) fail("si_unexpected");
                    else chk("si_bit", 32'(part_si), 32'(exp_si.pop_front()));
                end
            end
            if (!part_rstn) rst_low <= rst_low + 1;
        end
        pclk_prev <= part_clk;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(posedge clk); #1;
        while (!(state inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd7}) && t < BUDGET) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= BUDGET) fail("rx_pace");
        rx_data = b;
        rx_rcv  = 1'b1;
        @(posedge clk); #1;
        rx_rcv  = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] n);
        send_byte(c);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (state != 4'd5 && t < BUDGET) begin
            @(posedge clk); #1;
            t++;
        end
        if (state != 4'd5) fail(name);
    endtask

    task automatic push_tx(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, r0;
        logic [7:0] pat;
        pat = 8'b10001111;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_tx_start",  32'(tx_start),  32'd0);
        chk("rst_tx_data",   32'(tx_data),   32'd0);
        chk("rst_part_clk",  32'(part_clk),  32'd0);
        chk("rst_part_rstn", 32'(part_rstn), 32'd1);
        chk("rst_se_tm_si",  32'({part_se, part_tm, part_si}), 32'd0);
        chk("rst_pis",       32'(part_pis),  32'd0);
        rstn = 1'b1;
        wait_idle("boot_idle");
        chk("boot_state", 32'(state), 32'd5);

        // 'r': part_rstn low for exactly RST_CYCLES cycles
        r0 = rst_low;
        send_byte(8'h72);
        chk("r_low_next_cycle", 32'(part_rstn), 32'd0);
        wait_idle("r_idle");
        @(posedge clk); #1;
        chk("r_low_cycles", 32'(rst_low - r0), 32'd4);
        chk("r_rstn_high", 32'(part_rstn), 32'd1);

        // 'e': N pulses, and N=0 gives none
        e0 = edges;
        send_cmd(8'h65, 16'd10);
        wait_idle("e10_idle");
        @(posedge clk); #1;
        chk("e10_edges", 32'(edges - e0), 32'd10);
        e0 = edges;
        send_cmd(8'h65, 16'd0);
        chk("e0_state", 32'(state), 32'd5);
        repeat (4) @(posedge clk);
        #1;
        chk("e0_edges", 32'(edges - e0), 32'd0);

        // 's': scan-in 10001111
        for (int i = 7; i >= 0; i--) exp_si.push_back(pat[i]);
        mon_si = 1'b1;
        mon_scan = 1'b1;
        e0 = edges;
        send_cmd(8'h73, 16'd8);
        for (int i = 7; i >= 0; i--) send_byte(pat[i] ? 8'h31 : 8'h30);
        wait_idle("s_idle");
        mon_si = 1'b0;
        mon_scan = 1'b0;
        chk("s_edges", 32'(edges - e0), 32'd8);
        chk("s_si_pending", 32'(exp_si.size()), 32'd0);
        chk("s_se_tm_after", 32'({part_se, part_tm}), 32'd0);

        // 'o': 11 outputs, then an over-length read
        part_pos = {1'b0, 8'hA9, 2'b00};
        push_tx("01010100100");
        send_cmd(8'h6F, 16'd11);
        wait_idle("o11_idle");
        chk("o11_pending", 32'(exp_tx.size()), 32'd0);
        part_pos = '1;
        push_tx("1111111111100");
        send_cmd(8'h6F, 16'd13);
        wait_idle("o13_idle");
        chk("o13_pending", 32'(exp_tx.size()), 32'd0);

        // 'i': over-length write, then a partial write that keeps the rest
        send_cmd(8'h69, 16'd16);
        for (int i = 0; i < 16; i++) send_byte(8'h31);
        wait_idle("i16_idle");
        chk("i16_pis", 32'(part_pis), 32'h3FFF);
        send_cmd(8'h69, 16'd3);
        send_byte(8'h30);
        send_byte(8'h31);
        send_byte(8'h30);
        wait_idle("i3_idle");
        chk("i3_pis", 32'(part_pis), 32'h17FF);

        // 'g': read back the chain loaded by 's'
        push_tx("10001111");
        mon_scan = 1'b1;
        send_cmd(8'h67, 16'd8);
        wait_idle("g_idle");
        mon_scan = 1'b0;
        chk("g_pending", 32'(exp_tx.size()), 32'd0);
        chk("g_se_tm_after", 32'({part_se, part_tm}), 32'd0);

        // 'f' ... 'd': free-run then stop low
        e0 = edges;
        send_byte(8'h66);
        repeat (12) @(posedge clk);
        send_byte(8'h64);
        chk("f_state", 32'(state), 32'd5);
        chk("f_clk_low", 32'(part_clk), 32'd0);
        chk("f_ran", 32'((edges - e0) >= 5), 32'd1);
        e0 = edges;
        repeat (4) @(posedge clk);
        #1;
        chk("f_stopped", 32'(edges - e0), 32'd0);

        // Ignored bytes in IDLE
        send_byte(8'h78);
        chk("ignore_x", 32'(state), 32'd5);
        send_byte(8'h64);
        chk("ignore_d", 32'(state), 32'd5);

        // Abort a long 'e' with rstn
        send_cmd(8'h65, 16'hFFFF);
        repeat (7) @(posedge clk);
        #2;
        chk("abort_in_exec", 32'(state), 32'd4);
        rstn = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_clk_rstn", 32'({part_clk, part_rstn}), 32'd1);
        chk("abort_se_tm_si", 32'({part_se, part_tm, part_si}), 32'd0);
        chk("abort_pis", 32'(part_pis), 32'd0);
        chk("abort_tx", 32'({tx_start, tx_data}), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_idle("abort_recover");
        chk("abort_recover_state", 32'(state), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
